// File: rtl/thread_sched_rr.sv
// Thread scheduler: pending FIFO -> active slot table -> round-robin dispatch port.
// 1-cycle cmd response; RUN reaches disp 3 edges later; disp_* held while disp_valid && !disp_ready.
module thread_sched_rr #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int PEND_DEPTH = 8,
  parameter int ACT_SLOTS  = 8,
  localparam int SW  = $clog2(ACT_SLOTS),
  localparam int PW  = $clog2(PEND_DEPTH),
  localparam int PCW = $clog2(PEND_DEPTH + 1),
  localparam int ACW = $clog2(ACT_SLOTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic              rsp_ok,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic [SW-1:0]     disp_slot,
  output logic [PCW-1:0]    pend_count,
  output logic [ACW-1:0]    act_count,
  output logic              pend_full
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_FLUSH = 2'd3;

  entry_t               pend_mem_q [PEND_DEPTH];
  entry_t               slot_q     [ACT_SLOTS];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PCW-1:0]       pend_cnt_q, pend_cnt_d;
  logic [ACT_SLOTS-1:0] occ_q, occ_d, stop_q, stop_d;
  logic                 disp_valid_q, disp_valid_d;
  entry_t               disp_q, disp_d;
  logic [SW-1:0]        disp_slot_q, disp_slot_d, rr_ptr_q, rr_ptr_d;
  logic                 rsp_valid_q, rsp_valid_d, rsp_ok_q, rsp_ok_d;

  logic                 is_run, is_stop, is_flush, push, pop, stop_hit, free_any, found, load;
  logic [SW-1:0]        free_idx, pick, cand;
  logic [ACT_SLOTS-1:0] presented, free, eligible;
  logic [ACW-1:0]       act_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(PEND_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pend_full = (pend_cnt_q == PCW'(PEND_DEPTH));

  always_comb begin
    is_run   = cmd_valid && (cmd_op == OP_RUN);
    is_stop  = cmd_valid && (cmd_op == OP_STOP);
    is_flush = cmd_valid && (cmd_op == OP_FLUSH);
    push     = is_run && !pend_full;

    act_cnt = '0;
    for (int i = 0; i < ACT_SLOTS; i++) begin
      presented[i] = disp_valid_q && (disp_slot_q == SW'(i));
      free[i]      = !occ_q[i] || (stop_q[i] && !presented[i]);
      eligible[i]  = occ_q[i] && !stop_q[i];
      act_cnt      = act_cnt + ACW'(occ_q[i]);
    end

    free_any = 1'b0;
    free_idx = '0;
    for (int i = ACT_SLOTS - 1; i >= 0; i--) begin
      if (free[i]) begin
        free_any = 1'b1;
        free_idx = SW'(i);
      end
    end
    // FLUSH suppresses promotion so the popped head cannot escape the flush
    pop = (pend_cnt_q != '0) && free_any && !is_flush;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pend_cnt_d = pend_cnt_q;
    if (is_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pend_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      pend_cnt_d = pend_cnt_q + PCW'(1);
      else if (pop && !push) pend_cnt_d = pend_cnt_q - PCW'(1);
    end

    occ_d    = occ_q;
    stop_d   = stop_q;
    stop_hit = 1'b0;
    for (int i = 0; i < ACT_SLOTS; i++) begin
      if (is_stop && occ_q[i] && (slot_q[i].addr == cmd_addr)) begin
        stop_d[i] = 1'b1;
        stop_hit  = 1'b1;
      end
      // a stopped slot is released once it is off the port or being taken this edge
      if (occ_q[i] && stop_q[i] && (!presented[i] || disp_ready)) begin
        occ_d[i]  = 1'b0;
        stop_d[i] = 1'b0;
      end
    end
    if (pop) begin
      occ_d[free_idx]  = 1'b1;
      stop_d[free_idx] = 1'b0;
    end

    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = ACT_SLOTS; k >= 1; k--) begin
      cand = SW'((int'(rr_ptr_q) + k) % ACT_SLOTS);
      if (eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    load         = !disp_valid_q || disp_ready;
    disp_valid_d = disp_valid_q;
    disp_d       = disp_q;
    disp_slot_d  = disp_slot_q;
    rr_ptr_d     = rr_ptr_q;
    if (load) begin
      disp_valid_d = found;
      if (found) begin
        disp_d      = slot_q[pick];
        disp_slot_d = pick;
        rr_ptr_d    = pick;
      end
    end

    rsp_valid_d = cmd_valid && (cmd_op != 2'd0);
    rsp_ok_d    = push || stop_hit || is_flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pend_cnt_q   <= '0;
      occ_q        <= '0;
      stop_q       <= '0;
      disp_valid_q <= 1'b0;
      disp_q       <= '0;
      disp_slot_q  <= '0;
      rr_ptr_q     <= SW'(ACT_SLOTS - 1);
      rsp_valid_q  <= 1'b0;
      rsp_ok_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pend_cnt_q   <= pend_cnt_d;
      occ_q        <= occ_d;
      stop_q       <= stop_d;
      disp_valid_q <= disp_valid_d;
      disp_q       <= disp_d;
      disp_slot_q  <= disp_slot_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_ok_q     <= rsp_ok_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) pend_mem_q[wr_ptr_q] <= {cmd_data, cmd_addr};
    if (!rst && pop)  slot_q[free_idx]     <= pend_mem_q[rd_ptr_q];
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_ok     = rsp_ok_q;
  assign disp_valid = disp_valid_q;
  assign disp_addr  = disp_q.addr;
  assign disp_data  = disp_q.data;
  assign disp_slot  = disp_slot_q;
  assign pend_count = pend_cnt_q;
  assign act_count  = act_cnt;

endmodule

// File: tb/tb_thread_sched_rr.sv
// Directed bench for thread_sched_rr with hand-computed expectations.
module tb_thread_sched_rr;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid, rsp_ok, disp_valid;
  logic          disp_ready = 1'b0;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic [2:0]    disp_slot;
  logic [3:0]    pend_count;
  logic [3:0]    act_count;
  logic          pend_full;

  int total = 0;
  int bad   = 0;

  thread_sched_rr dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_slot(disp_slot),
    .pend_count(pend_count), .act_count(act_count), .pend_full(pend_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
  endtask

  initial begin
    logic       seen;
    logic [2:0] rr_exp [8];
    logic [2:0] post_exp [3];
    rr_exp   = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
    post_exp = '{3'd0, 3'd2, 3'd0};

    // reset and idle
    tick();
    tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_ok", rsp_ok, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_addr", disp_addr, 0);
    chk("rst_disp_slot", disp_slot, 0);
    chk("rst_pend_count", pend_count, 0);
    chk("rst_act_count", act_count, 0);
    chk("rst_pend_full", pend_full, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (disp_valid || rsp_valid) seen = 1'b1;
    end
    chk("idle_quiet", seen, 0);

    // single thread latency and re-presentation
    disp_ready = 1'b1;
    send(2'd1, 32'h100, 32'hAA);
    chk("run1_rsp", {rsp_valid, rsp_ok}, 2'b11);
    chk("run1_pend", pend_count, 1);
    chk("run1_disp_e1", disp_valid, 0);
    tick();
    chk("run1_rsp_pulse", rsp_valid, 0);
    chk("run1_act", act_count, 1);
    chk("run1_pend_pop", pend_count, 0);
    chk("run1_disp_e2", disp_valid, 0);
    tick();
    chk("run1_disp_e3", {disp_valid, disp_slot}, {1'b1, 3'd0});
    chk("run1_addr", disp_addr, 32'h100);
    chk("run1_data", disp_data, 32'hAA);
    repeat (3) begin
      tick();
      chk("run1_repeat", {disp_valid, disp_slot, disp_addr}, {1'b1, 3'd0, 32'h100});
    end
    rst = 1'b1;
    tick();
    chk("midrst_disp_valid", disp_valid, 0);
    chk("midrst_act", act_count, 0);
    chk("midrst_rsp", rsp_valid, 0);
    rst = 1'b0;

    // fill everything with disp_ready low
    disp_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send(2'd1, 32'h1000 + i, i);
      chk("fill_rsp", {rsp_valid, rsp_ok}, 2'b11);
      if (i > 0) chk("fill_pend_steady", pend_count, 1);
    end
    chk("fill_act", act_count, 8);
    chk("fill_pend", pend_count, 1);
    chk("fill_disp", {disp_valid, disp_slot, disp_addr}, {1'b1, 3'd0, 32'h1000});
    for (int i = 0; i < 2; i++) begin
      send(2'd1, 32'h1100 + i, i);
      chk("fill2_rsp", {rsp_valid, rsp_ok}, 2'b11);
    end
    chk("fill2_pend", pend_count, 3);
    send(2'd3, 32'h0, 32'h0);
    chk("flush_rsp", {rsp_valid, rsp_ok}, 2'b11);
    chk("flush_pend", pend_count, 0);
    chk("flush_act", act_count, 8);
    chk("flush_full", pend_full, 0);
    for (int i = 0; i < 8; i++) begin
      send(2'd1, 32'h2000 + i, i);
      chk("refill_rsp", {rsp_valid, rsp_ok}, 2'b11);
    end
    chk("refill_pend", pend_count, 8);
    chk("refill_full", pend_full, 1);
    send(2'd1, 32'h3000, 32'h0);
    chk("full_reject", {rsp_valid, rsp_ok}, 2'b10);
    chk("full_pend", pend_count, 8);
    send(2'd0, 32'h3000, 32'h0);
    chk("nop_rsp", rsp_valid, 0);
    chk("nop_pend", pend_count, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // round robin over three threads
    disp_ready = 1'b1;
    send(2'd1, 32'h10, 32'h1);
    send(2'd1, 32'h20, 32'h2);
    send(2'd1, 32'h30, 32'h3);
    chk("rr_rsp", {rsp_valid, rsp_ok}, 2'b11);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      chk("rr_order", {disp_valid, disp_slot, disp_addr},
          {1'b1, rr_exp[k], 32'h10 * (32'(rr_exp[k]) + 1)});
    end

    // stop the presented slot while back-pressured
    disp_ready = 1'b0;
    send(2'd2, 32'h20, 32'h0);
    chk("stop_rsp", {rsp_valid, rsp_ok}, 2'b11);
    chk("stop_held", {disp_valid, disp_slot, disp_addr}, {1'b1, 3'd1, 32'h20});
    chk("stop_act3", act_count, 3);
    tick();
    chk("stop_held2", {disp_valid, disp_slot}, {1'b1, 3'd1});
    chk("stop_act3b", act_count, 3);
    disp_ready = 1'b1;
    tick();
    chk("stop_freed", act_count, 2);
    chk("stop_next", {disp_valid, disp_slot}, {1'b1, 3'd2});
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stop_order", {disp_valid, disp_slot}, {1'b1, post_exp[k]});
    end
    send(2'd2, 32'h999, 32'h0);
    chk("stop_nomatch", {rsp_valid, rsp_ok}, 2'b10);
    chk("stop_nomatch_act", act_count, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
